// File: rtl/lsu_if.sv
// Bundled request/response and data-memory signals of the load/store unit.
// LSU_BYTE_MASK_EN adds the mem_be lane-enable signal.
interface lsu_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
`ifdef LSU_BYTE_MASK_EN
    logic [3:0]        mem_be;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_addr, mem_wdata, mem_be
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_addr, mem_wdata, mem_be
    );
`else
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_addr, mem_wdata
    );
`endif
endinterface

// File: rtl/lsu_ctrl.sv
// RISC-V load/store controller for a word-wide memory: sub-word extraction and
// read-modify-write stores. Define LSU_BYTE_MASK_EN for byte-enable stores instead of RMW.
module lsu_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        off_reg;
    logic [31:0]       wdata_reg;
    logic              err_reg;
    logic [31:0]       rdata_reg;
    logic [ADDR_W-1:0] mem_addr_reg;

    logic              accept;
    logic              req_err;
    logic [31:0]       load_ext;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [3:0]        lane_en;
    logic              mem_we_c;
    logic [31:0]       mem_wdata_c;

    // Only the word index and lane offset of the byte address matter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

    assign bus.req_ready = (state_reg == IDLE) & ~rst;
    assign accept        = bus.req_valid & bus.req_ready;

    always_comb begin
        req_err = 1'b0;
        if (bus.req_we) begin
            req_err = (bus.req_funct3 > 3'd2) ||
                      (bus.req_funct3 == 3'd1 && bus.req_addr[0]) ||
                      (bus.req_funct3 == 3'd2 && bus.req_addr[1:0] != 2'd0);
        end else begin
            case (bus.req_funct3)
                3'd1, 3'd5: req_err = bus.req_addr[0];
                3'd2:       req_err = (bus.req_addr[1:0] != 2'd0);
                3'd3, 3'd6, 3'd7: req_err = 1'b1;
                default:    req_err = 1'b0;
            endcase
        end
    end

    assign sel_byte = bus.mem_rdata[8*off_reg +: 8];
    assign sel_half = off_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        load_ext = 32'd0;
        case (funct3_reg)
            3'd0:    load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'd1:    load_ext = {{16{sel_half[15]}}, sel_half};
            3'd2:    load_ext = bus.mem_rdata;
            3'd4:    load_ext = {24'd0, sel_byte};
            3'd5:    load_ext = {16'd0, sel_half};
            default: load_ext = 32'd0;
        endcase
    end

    // Byte lanes touched by a sub-word store (SB: one lane, SH: the aligned pair).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_en[gi] = (funct3_reg[1:0] == 2'd0) ? (off_reg == 2'(gi))
                                                           : (off_reg[1] == 1'(gi / 2));
        end
    endgenerate

`ifndef LSU_BYTE_MASK_EN
    logic [31:0] word_reg;
    logic [31:0] merged_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] =
                !lane_en[gi]              ? word_reg[8*gi +: 8] :
                (funct3_reg[1:0] == 2'd0) ? wdata_reg[7:0]      :
                                            wdata_reg[8*(gi%2) +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg <= 32'd0;
        end else if (state_reg == ACCESS) begin
            word_reg <= bus.mem_rdata;
        end
    end
`else
    logic [3:0] mem_be_c;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
`ifdef LSU_BYTE_MASK_EN
                state_next = RESP;
`else
                state_next = (!we_reg || funct3_reg[1:0] == 2'd2) ? RESP : WRITE;
`endif
            end
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_we_c    = 1'b0;
        mem_wdata_c = 32'd0;
`ifdef LSU_BYTE_MASK_EN
        mem_be_c    = 4'd0;
        if (state_reg == ACCESS && we_reg) begin
            mem_we_c = 1'b1;
            case (funct3_reg[1:0])
                2'd0:    begin mem_wdata_c = {4{wdata_reg[7:0]}};  mem_be_c = lane_en; end
                2'd1:    begin mem_wdata_c = {2{wdata_reg[15:0]}}; mem_be_c = lane_en; end
                default: begin mem_wdata_c = wdata_reg;            mem_be_c = 4'hF;    end
            endcase
        end
`else
        if (state_reg == ACCESS && we_reg && funct3_reg[1:0] == 2'd2) begin
            mem_we_c    = 1'b1;
            mem_wdata_c = wdata_reg;
        end else if (state_reg == WRITE) begin
            mem_we_c    = 1'b1;
            mem_wdata_c = merged_word;
        end
`endif
        // A write never commits while reset is asserted, even mid-request.
        if (rst) begin
            mem_we_c    = 1'b0;
            mem_wdata_c = 32'd0;
`ifdef LSU_BYTE_MASK_EN
            mem_be_c    = 4'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            funct3_reg   <= 3'd0;
            off_reg      <= 2'd0;
            wdata_reg    <= 32'd0;
            err_reg      <= 1'b0;
            rdata_reg    <= 32'd0;
            mem_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg     <= bus.req_we;
                funct3_reg <= bus.req_funct3;
                off_reg    <= bus.req_addr[1:0];
                wdata_reg  <= bus.req_wdata;
                err_reg    <= req_err;
                rdata_reg  <= 32'd0;
                // mem_addr must be valid at the start of ACCESS for the async read.
                if (!req_err) begin
                    mem_addr_reg <= bus.req_addr[ADDR_W+1:2];
                end
            end
            if (state_reg == ACCESS && !we_reg) begin
                rdata_reg <= load_ext;
            end
        end
    end

    assign bus.resp_valid = (state_reg == RESP) & ~rst;
    assign bus.resp_err   = bus.resp_valid & err_reg;
    assign bus.resp_rdata = rdata_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_wdata  = mem_wdata_c;
`ifdef LSU_BYTE_MASK_EN
    assign bus.mem_be     = mem_be_c;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus random requests scored
// against an arithmetic model of the load/store rules and a shadow memory.
module tb_lsu_ctrl;

    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;
    int   we_total = 0;

    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:15];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    lsu_if #(.ADDR_W(AW)) bus ();

    lsu_ctrl #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.mem_we) begin
            we_total++;
`ifdef LSU_BYTE_MASK_EN
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
`else
            mem[bus.mem_addr] <= bus.mem_wdata;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        int unsigned o = off;
        if (we) return (f3 > 2) || (f3 == 1 && o % 2 == 1) || (f3 == 2 && o != 0);
        return (f3 == 3 || f3 == 6 || f3 == 7) ||
               ((f3 == 1 || f3 == 5) && o % 2 == 1) || (f3 == 2 && o != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
        int unsigned o = off;
        int unsigned b = (word >> (8 * o)) % 256;
        int unsigned h = (word >> (16 * (o / 2))) % 65536;
        case (f3)
            3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2: return word;
            3'd4: return b;
            3'd5: return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [1:0] off, input logic [31:0] wd);
        int unsigned o = off;
        logic [31:0] mask, val;
        if (f3 == 0) begin
            mask = 32'hFF << (8 * o);
            val  = (wd % 256) << (8 * o);
        end else if (f3 == 1) begin
            mask = 32'hFFFF << (8 * o);
            val  = (wd % 65536) << (8 * o);
        end else begin
            mask = 32'hFFFF_FFFF;
            val  = wd;
        end
        return (word & ~mask) | val;
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
        int unsigned idx = addr[5:2];
        logic [1:0]  off = addr[1:0];
        logic        e_err = m_err(we, f3, off);
        logic        is_wr = we && !e_err;
        logic [31:0] old_word = ref_mem[idx];
        logic [31:0] e_word = is_wr ? m_store(old_word, f3, off, wd) : old_word;
        logic [31:0] e_rd = (we || e_err) ? 32'd0 : m_load(old_word, f3, off);
        int          e_lat, e_we_at;
        logic [31:0] e_wdata;
        int w = 0, lat = 0, we_seen = 0, we_at = 0;
        logic [31:0] got_wd = 32'd0;
`ifdef LSU_BYTE_MASK_EN
        logic [3:0]  got_be = 4'd0;
        logic [3:0]  e_be = (f3 == 0) ? 4'b0001 << off : (f3 == 1) ? 4'b0011 << off : 4'hF;
        e_lat   = e_err ? 1 : 2;
        e_we_at = 1;
        e_wdata = (f3 == 0) ? (wd % 256) * 32'h0101_0101 :
                  (f3 == 1) ? (wd % 65536) * 32'h0001_0001 : wd;
`else
        e_lat   = e_err ? 1 : (we && f3 != 2) ? 3 : 2;
        e_we_at = (f3 == 2) ? 1 : 2;
        e_wdata = e_word;
`endif
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        while (!bus.req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        do begin
            @(negedge clk);
            lat++;
            if (bus.mem_we) begin
                we_seen++;
                we_at  = lat;
                got_wd = bus.mem_wdata;
`ifdef LSU_BYTE_MASK_EN
                got_be = bus.mem_be;
`endif
            end
        end while (!bus.resp_valid && lat < 8);
        rd = bus.resp_rdata;
        chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
        chk({tag, "_rdata"}, bus.resp_rdata, e_rd);
        chk({tag, "_err"}, 32'(bus.resp_err), 32'(e_err));
        chk({tag, "_we_cnt"}, 32'(we_seen), is_wr ? 32'd1 : 32'd0);
        if (is_wr) begin
            chk({tag, "_we_at"}, 32'(we_at), 32'(e_we_at));
            chk({tag, "_wdata"}, got_wd, e_wdata);
`ifdef LSU_BYTE_MASK_EN
            chk({tag, "_be"}, 32'(got_be), 32'(e_be));
`endif
        end
        @(negedge clk);
        chk({tag, "_resp_once"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
        ref_mem[idx] = e_word;
        chk({tag, "_memword"}, mem[idx], e_word);
        $display("req %s we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 tag, we, f3, addr, wd, rd, bus.resp_err, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] word_before;
        int          we_before;

        rst = 1'b1;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = (i == 5) ? 32'h8899_AABB : $urandom;
            @(negedge clk);
            pre_we = 1'b1;
            pre_addr = AW'(i);
            pre_data = ref_mem[i];
        end
        @(negedge clk);
        pre_we = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
`ifdef LSU_BYTE_MASK_EN
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        do_req("lb",  1'b0, 3'd0, 32'h15, 32'd0, rd);  chk("lb_val",  rd, 32'hFFFF_FFAA);
        do_req("lbu", 1'b0, 3'd4, 32'h15, 32'd0, rd);  chk("lbu_val", rd, 32'h0000_00AA);
        do_req("lh",  1'b0, 3'd1, 32'h16, 32'd0, rd);  chk("lh_val",  rd, 32'hFFFF_8899);
        do_req("lhu", 1'b0, 3'd5, 32'h14, 32'd0, rd);  chk("lhu_val", rd, 32'h0000_AABB);
        do_req("lw",  1'b0, 3'd2, 32'h14, 32'd0, rd);  chk("lw_val",  rd, 32'h8899_AABB);
        do_req("sb",  1'b1, 3'd0, 32'h14, 32'h1234_5677, rd);
        do_req("lw2", 1'b0, 3'd2, 32'h14, 32'd0, rd);  chk("lw2_val", rd, 32'h8899_AA77);
        do_req("sh",  1'b1, 3'd1, 32'h16, 32'h0000_CAFE, rd);
        chk("sh_word", mem[5], 32'hCAFE_AA77);
        do_req("e_lw",  1'b0, 3'd2, 32'h16, 32'd0, rd);
        do_req("e_sh",  1'b1, 3'd1, 32'h13, 32'hFFFF_FFFF, rd);
        do_req("e_f3",  1'b0, 3'd3, 32'h14, 32'd0, rd);
        do_req("e_sf3", 1'b1, 3'd5, 32'h14, 32'd0, rd);
        do_req("lw_hi", 1'b0, 3'd2, 32'hABCD_0014, 32'd0, rd);
        chk("lw_hi_val", rd, 32'hCAFE_AA77);
`ifdef LSU_BYTE_MASK_EN
        do_req("sb_be", 1'b1, 3'd0, 32'h17, 32'h0000_005A, rd);
        chk("sb_be_word", mem[5], 32'h5A_FEAA77);
`endif

        // Reset during the cycle in which the SB write would commit.
        word_before = mem[6];
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr = 32'h19;
        bus.req_wdata = 32'h0000_00C3;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        we_before = we_total;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
`ifndef LSU_BYTE_MASK_EN
        @(posedge clk);
        #1;
`endif
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort_resp", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
            @(negedge clk);
        end
        chk("abort_we_total", 32'(we_total), 32'(we_before));
        chk("abort_word", mem[6], word_before);
        $display("req abort sb addr=00000019 -> word=%h", mem[6]);

        for (int n = 0; n < 60; n++) begin
            logic        r_we = 1'($urandom_range(0, 1));
            logic [2:0]  r_f3 = 3'($urandom_range(0, 7));
            logic [31:0] r_addr = {16'($urandom), 10'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            do_req($sformatf("rnd%0d", n), r_we, r_f3, r_addr, $urandom, rd);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- CPU-side load/store initiator that drives the word-organised data memory.
- Accepts RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) from the execute stage and forms the word address.
- Does byte/halfword extraction with sign or zero extension.
- Runs read-modify-write for sub-word stores, because the memory only supports whole-word writes.
- Flags misaligned and illegal accesses.

Parameters:
- ADDR_W, 14, word-address width presented to the memory (depth 2^ADDR_W words).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request strobe
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned/illegal flag, valid with resp_valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  asynchronous read data of the word at mem_addr

Behaviour:
- Reset: state IDLE. req_ready, resp_valid, resp_err, mem_we = 0. resp_rdata, mem_addr, mem_wdata = 0. mem_we is gated by ~rst, so no write commits in any cycle where rst is high.
- req_ready = (state == IDLE) & ~rst.
- On accept, latch we, funct3, word index = req_addr[ADDR_W+1:2], offset = req_addr[1:0], and wdata. The upper address bits are ignored.
- Error check at accept; any of these is an error:
  - LH/LHU/SH with offset[0] = 1.
  - LW/SW with offset != 0.
  - Load funct3 in {3, 6, 7}.
  - Store funct3 > 2.
- FSM states: IDLE, ACCESS, WRITE, RESP.
  - IDLE -> RESP on accept with error. resp_err = 1, no memory cycle, response 1 cycle after accept.
  - IDLE -> ACCESS on any other accept.
  - ACCESS: mem_addr = latched index.
    - Load: capture mem_rdata -> RESP.
    - SW: mem_we = 1, mem_wdata = wdata -> RESP.
    - SB/SH: capture mem_rdata -> WRITE.
  - WRITE: mem_we = 1, mem_wdata = captured word with the selected byte/half replaced by the low bits of wdata (little-endian, lane = offset) -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle -> IDLE.
- Latency from accept to resp_valid: 2 cycles for loads and SW, 3 cycles for SB/SH, 1 cycle for errors.
- Load extraction, little-endian:
  - LB/LBU: byte at offset, sign- or zero-extended.
  - LH/LHU: half at offset[1], sign- or zero-extended.
  - LW: full word.
- mem_addr holds its last value outside ACCESS/WRITE. mem_we is asserted at most once per request.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP. There is no pipelining and never more than one request outstanding.
- req_valid while not ready: the request is ignored. The requester holds it until it is accepted.
- Reset mid-operation (ACCESS/WRITE/RESP): the request is aborted and no write commits. No resp_valid is produced. The FSM is in IDLE the next cycle.

Optional Feature:
- Macro: LSU_BYTE_MASK_EN.
- Defined:
  - Adds output mem_be[3:0] (reset 0).
  - SB asserts one lane bit, SH asserts two, SW asserts 4'hF.
  - Store data is replicated across lanes.
  - SB/SH skip WRITE and commit in ACCESS, so latency is 2 cycles.
  - mem_be = 0 whenever mem_we = 0.
- Undefined: no mem_be port; the RMW path above is used.

Test Plan:
- Preload word 5 = 0x8899AABB. LB @0x15 -> resp_rdata 0xFFFFFFAA. LBU @0x15 -> 0x000000AA. Both with resp_valid 2 cycles after accept and mem_we never asserted.
- LH @0x16 -> 0xFFFF8899. LHU @0x14 -> 0x0000AABB. LW @0x14 -> 0x8899AABB.
- SB @0x14, wdata 0x12345677 -> one mem_we pulse in the cycle 2 after accept with mem_wdata 0x8899AA77, resp 3 cycles after accept. Follow-up LW @0x14 returns 0x8899AA77. Then SH @0x16, wdata 0xCAFE -> word becomes 0xCAFEAA77.
- LW @0x16, SH @0x13, load funct3 = 3 -> each gives resp_err = 1 and resp_rdata = 0 one cycle after accept, no mem_we, req_ready back high the next cycle.
- SB issued, rst asserted during the WRITE cycle -> no mem_we pulse, word unchanged, no resp_valid, req_ready = 1 in the cycle after rst deasserts.
- With LSU_BYTE_MASK_EN: SB @0x17, wdata 0x5A -> mem_be 4'b1000, mem_wdata 0x5A5A5A5A, response 2 cycles after accept.
